// File: rtl/processor_ctrl_pkg.sv
// Shared encodings for the stack processor control unit: opcodes, FSM states,
// datapath control field values and the packed control word.
package processor_ctrl_pkg;

  localparam logic [4:0] OP_PUSHI = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_POP   = 5'b00101;
  localparam logic [4:0] OP_BRZ   = 5'b00110;
  localparam logic [4:0] OP_JMP   = 5'b00111;
  localparam logic [4:0] OP_CALL  = 5'b01000;
  localparam logic [4:0] OP_RET   = 5'b01001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_ODPP   = 4'd3,
    ST_PUSH   = 4'd4,
    ST_EXEC   = 4'd5,
    ST_POP    = 4'd6,
    ST_BRZ    = 4'd7,
    ST_JMP    = 4'd8,
    ST_CALL1  = 4'd9,
    ST_CALL2  = 4'd10,
    ST_RET1   = 4'd11,
    ST_RET2   = 4'd12,
    ST_HALT   = 4'd13,
    ST_TRAP   = 4'd14
  } state_t;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_RS  = 2'b10;

  localparam logic [1:0] PTR_HOLD = 2'b00;
  localparam logic [1:0] PTR_INC  = 2'b01;
  localparam logic [1:0] PTR_DEC  = 2'b10;

  localparam logic [1:0] MADDR_PC = 2'b00;
  localparam logic [1:0] MADDR_DP = 2'b01;
  localparam logic [1:0] MADDR_RP = 2'b10;

  localparam logic       MDATA_TR  = 1'b0;
  localparam logic       MDATA_PC1 = 1'b1;

  localparam logic [2:0] TR_SRC_ALU = 3'b001;
  localparam logic [2:0] TR_SRC_IMM = 3'b011;

  localparam logic [2:0] B_SRC_STACK = 3'b000;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_enable;
    logic [1:0] rp_inc;
    logic [1:0] dp_inc;
    logic [1:0] mem_addr;
    logic       mem_data;
    logic       mem_write;
    logic       ir_write;
    logic [2:0] tr_src;
    logic       tr_write;
    logic       reg_write;
    logic [2:0] b_src;
    logic       b_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       halted;
    logic       trap;
  } ctrl_word_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Pure combinational decode of the FSM state (plus values captured in DECODE)
// into the datapath control word.
module ctrl_word_decode
  import processor_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_is_zero,
  input  logic [3:0] i_alu_op,
  output ctrl_word_t o_cw
);

  always_comb begin
    // Working states keep the B register loading unless they say otherwise.
    o_cw         = '0;
    o_cw.b_write = 1'b1;
    case (i_state)
      ST_RST: o_cw.b_write = 1'b0;
      ST_FETCH: begin
        o_cw.mem_addr  = MADDR_PC;
        o_cw.ir_write  = 1'b1;
        o_cw.pc_src    = PC_SRC_INC;
        o_cw.pc_enable = 1'b1;
      end
      ST_DECODE: o_cw.b_src = B_SRC_STACK;
      ST_ODPP: begin
        o_cw.dp_inc  = PTR_INC;
        o_cw.b_write = 1'b0;
      end
      ST_PUSH: begin
        o_cw.reg_write = 1'b1;
        o_cw.tr_src    = TR_SRC_IMM;
        o_cw.tr_write  = 1'b1;
      end
      ST_EXEC: begin
        o_cw.dp_inc   = PTR_DEC;
        o_cw.tr_src   = TR_SRC_ALU;
        o_cw.tr_write = 1'b1;
        o_cw.alu_src  = 1'b1;
        o_cw.alu_op   = i_alu_op;
      end
      ST_POP: o_cw.dp_inc = PTR_DEC;
      ST_BRZ: begin
        o_cw.dp_inc    = PTR_DEC;
        o_cw.pc_src    = PC_SRC_IMM;
        o_cw.pc_enable = i_is_zero;
      end
      ST_JMP, ST_CALL2: begin
        o_cw.pc_src    = PC_SRC_IMM;
        o_cw.pc_enable = 1'b1;
      end
      ST_CALL1: begin
        o_cw.mem_addr  = MADDR_RP;
        o_cw.mem_data  = MDATA_PC1;
        o_cw.mem_write = 1'b1;
        o_cw.rp_inc    = PTR_INC;
      end
      ST_RET1: o_cw.rp_inc = PTR_DEC;
      ST_RET2: begin
        o_cw.mem_addr  = MADDR_RP;
        o_cw.pc_src    = PC_SRC_RS;
        o_cw.pc_enable = 1'b1;
      end
      ST_HALT: begin
        o_cw.b_write = 1'b0;
        o_cw.halted  = 1'b1;
      end
      ST_TRAP: begin
        o_cw.b_write = 1'b0;
        o_cw.trap    = 1'b1;
      end
      default: o_cw.b_write = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_control_unit.sv
// Multicycle control FSM for the stack processor; outputs come from the state
// register and values captured in DECODE, so inputs never reach outputs directly.
module stack_control_unit
  import processor_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                isZero,
  input  logic                ovfl,
  output logic [1:0]          pc_src,
  output logic                pc_enable,
  output logic [1:0]          rp_inc,
  output logic [1:0]          dp_inc,
  output logic [1:0]          mem_addr,
  output logic                mem_data,
  output logic                mem_write,
  output logic                ir_write,
  output logic [2:0]          tr_src,
  output logic                tr_write,
  output logic                reg_write,
  output logic [2:0]          b_src,
  output logic                b_write,
  output logic                alu_src,
  output logic [3:0]          alu_op,
  output logic                halted,
  output logic                trap
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_is_zero;
  logic [3:0] r_alu_op;
  ctrl_word_t w_cw;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RST;
      r_is_zero <= 1'b0;
      r_alu_op  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_is_zero <= isZero;
        r_alu_op  <= {1'b0, opcode[2:0]};
      end
    end
  end

  always_comb begin
    w_state_next = ST_TRAP;
    case (r_state)
      ST_RST:    w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_PUSHI:                       w_state_next = ST_ODPP;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  w_state_next = ST_EXEC;
          OP_POP:                         w_state_next = ST_POP;
          OP_BRZ:                         w_state_next = ST_BRZ;
          OP_JMP:                         w_state_next = ST_JMP;
          OP_CALL:                        w_state_next = ST_CALL1;
          OP_RET:                         w_state_next = ST_RET1;
          OP_HALT:                        w_state_next = ST_HALT;
          default:                        w_state_next = ST_TRAP;
        endcase
      end
      ST_ODPP:   w_state_next = ST_PUSH;
      ST_EXEC:   w_state_next = ovfl ? ST_TRAP : ST_FETCH;
      ST_PUSH, ST_POP, ST_BRZ, ST_JMP, ST_CALL2, ST_RET2:
                 w_state_next = ST_FETCH;
      ST_CALL1:  w_state_next = ST_CALL2;
      ST_RET1:   w_state_next = ST_RET2;
      ST_HALT:   w_state_next = ST_HALT;
      ST_TRAP:   w_state_next = ST_TRAP;
      default:   w_state_next = ST_TRAP;
    endcase
  end

  ctrl_word_decode u_decode (
    .i_state   (r_state),
    .i_is_zero (r_is_zero),
    .i_alu_op  (r_alu_op),
    .o_cw      (w_cw)
  );

  assign pc_src    = w_cw.pc_src;
  assign pc_enable = w_cw.pc_enable;
  assign rp_inc    = w_cw.rp_inc;
  assign dp_inc    = w_cw.dp_inc;
  assign mem_addr  = w_cw.mem_addr;
  assign mem_data  = w_cw.mem_data;
  assign mem_write = w_cw.mem_write;
  assign ir_write  = w_cw.ir_write;
  assign tr_src    = w_cw.tr_src;
  assign tr_write  = w_cw.tr_write;
  assign reg_write = w_cw.reg_write;
  assign b_src     = w_cw.b_src;
  assign b_write   = w_cw.b_write;
  assign alu_src   = w_cw.alu_src;
  assign alu_op    = w_cw.alu_op;
  assign halted    = w_cw.halted;
  assign trap      = w_cw.trap;

endmodule

// File: tb/tb_stack_control_unit.sv
// Bench for stack_control_unit: instruction-level model feeds a queue of
// expected control words, checked every cycle at the falling edge.
module tb_stack_control_unit;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_enable;
    logic [1:0] rp_inc;
    logic [1:0] dp_inc;
    logic [1:0] mem_addr;
    logic       mem_data;
    logic       mem_write;
    logic       ir_write;
    logic [2:0] tr_src;
    logic       tr_write;
    logic       reg_write;
    logic [2:0] b_src;
    logic       b_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       halted;
    logic       trap;
  } cw_t;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       isZero = 1'b0;
  logic       ovfl = 1'b0;

  logic [1:0] pc_src;
  logic       pc_enable;
  logic [1:0] rp_inc;
  logic [1:0] dp_inc;
  logic [1:0] mem_addr;
  logic       mem_data;
  logic       mem_write;
  logic       ir_write;
  logic [2:0] tr_src;
  logic       tr_write;
  logic       reg_write;
  logic [2:0] b_src;
  logic       b_write;
  logic       alu_src;
  logic [3:0] alu_op;
  logic       halted;
  logic       trap;

  int  n_checks = 0;
  int  n_errors = 0;
  cw_t q_exp[$];
  cw_t dut_cw;

  stack_control_unit #(.OPCODE_W(5)) dut (
    .CLK(CLK), .reset_n(reset_n), .opcode(opcode), .isZero(isZero), .ovfl(ovfl),
    .pc_src(pc_src), .pc_enable(pc_enable), .rp_inc(rp_inc), .dp_inc(dp_inc),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .ir_write(ir_write), .tr_src(tr_src), .tr_write(tr_write),
    .reg_write(reg_write), .b_src(b_src), .b_write(b_write), .alu_src(alu_src),
    .alu_op(alu_op), .halted(halted), .trap(trap)
  );

  assign dut_cw = {pc_src, pc_enable, rp_inc, dp_inc, mem_addr, mem_data, mem_write,
                   ir_write, tr_src, tr_write, reg_write, b_src, b_write, alu_src,
                   alu_op, halted, trap};

  always #5 CLK = ~CLK;

  task automatic check_word(input string name, input cw_t exp);
    n_checks++;
    if (dut_cw !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, dut_cw, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q_exp.size() > 0) check_word("cycle_word", q_exp.pop_front());
  end

  function automatic cw_t base_word();
    cw_t w = '0;
    w.b_write = 1'b1;
    return w;
  endfunction

  function automatic cw_t term_word(input int term);
    cw_t w = '0;
    if (term == 1) w.halted = 1'b1;
    else w.trap = 1'b1;
    return w;
  endfunction

  // Instruction-level model: term 0 = back to FETCH, 1 = HALT, 2 = TRAP.
  task automatic model_instr(input logic [4:0] op, input logic z, input logic v,
                             output int n, output int term);
    cw_t w;
    w = base_word(); w.ir_write = 1'b1; w.pc_enable = 1'b1;
    q_exp.push_back(w);
    q_exp.push_back(base_word());
    n = 2;
    term = 0;
    case (op)
      5'd0: begin
        w = base_word(); w.dp_inc = 2'b01; w.b_write = 1'b0; q_exp.push_back(w);
        w = base_word(); w.reg_write = 1'b1; w.tr_src = 3'b011; w.tr_write = 1'b1;
        q_exp.push_back(w);
        n = 4;
      end
      5'd1, 5'd2, 5'd3, 5'd4: begin
        w = base_word(); w.dp_inc = 2'b10; w.tr_src = 3'b001; w.tr_write = 1'b1;
        w.alu_src = 1'b1; w.alu_op = {1'b0, op[2:0]};
        q_exp.push_back(w);
        n = 3;
        if (v) term = 2;
      end
      5'd5: begin
        w = base_word(); w.dp_inc = 2'b10; q_exp.push_back(w); n = 3;
      end
      5'd6: begin
        w = base_word(); w.dp_inc = 2'b10; w.pc_src = 2'b01; w.pc_enable = z;
        q_exp.push_back(w); n = 3;
      end
      5'd7: begin
        w = base_word(); w.pc_src = 2'b01; w.pc_enable = 1'b1; q_exp.push_back(w); n = 3;
      end
      5'd8: begin
        w = base_word(); w.mem_addr = 2'b10; w.mem_data = 1'b1; w.mem_write = 1'b1;
        w.rp_inc = 2'b01; q_exp.push_back(w);
        w = base_word(); w.pc_src = 2'b01; w.pc_enable = 1'b1; q_exp.push_back(w);
        n = 4;
      end
      5'd9: begin
        w = base_word(); w.rp_inc = 2'b10; q_exp.push_back(w);
        w = base_word(); w.mem_addr = 2'b10; w.pc_src = 2'b10; w.pc_enable = 1'b1;
        q_exp.push_back(w);
        n = 4;
      end
      5'd31: term = 1;
      default: term = 2;
    endcase
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_instr(input logic [4:0] op, input logic z, input logic v,
                             output int n, output int term);
    opcode = op;
    isZero = z;
    ovfl   = v;
    model_instr(op, z, v, n, term);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic z, input logic v,
                           output int term);
    int n;
    start_instr(op, z, v, n, term);
    repeat (n) step();
  endtask

  task automatic hold_term(input int term, input int k);
    repeat (k) q_exp.push_back(term_word(term));
    repeat (k) step();
  endtask

  // Called just after a rising edge; returns just after the edge that enters FETCH.
  task automatic apply_reset();
    reset_n = 1'b0;
    q_exp.delete();
    #1;
    check_word("reset_immediate", '0);
    repeat (3) q_exp.push_back('0);
    repeat (2) @(posedge CLK);
    #1;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int n, term;
    logic [4:0] op;
    @(posedge CLK);
    #1;
    apply_reset();
    check_val("fetch_after_reset", int'(ir_write), 1);

    run_instr(5'd0, 1'b0, 1'b0, term);
    run_instr(5'd0, 1'b0, 1'b0, term);
    start_instr(5'd1, 1'b0, 1'b0, n, term);
    repeat (2) step();
    check_val("add_alu_op", int'(alu_op), 1);
    check_val("add_dp_inc", int'(dp_inc), 2);
    check_val("add_tr_src", int'(tr_src), 1);
    repeat (n - 2) step();

    start_instr(5'd2, 1'b0, 1'b0, n, term);
    repeat (2) step();
    apply_reset();
    check_val("fetch_after_exec_reset", int'(ir_write), 1);

    start_instr(5'd6, 1'b1, 1'b0, n, term);
    repeat (2) step();
    check_val("brz_taken_en", int'(pc_enable), 1);
    check_val("brz_taken_src", int'(pc_src), 1);
    repeat (n - 2) step();
    start_instr(5'd6, 1'b0, 1'b0, n, term);
    repeat (2) step();
    check_val("brz_not_taken_en", int'(pc_enable), 0);
    repeat (n - 2) step();

    start_instr(5'd8, 1'b0, 1'b0, n, term);
    repeat (2) step();
    check_val("call1_rp_inc", int'(rp_inc), 1);
    check_val("call1_mem_write", int'(mem_write), 1);
    check_val("call1_mem_addr", int'(mem_addr), 2);
    repeat (n - 2) step();
    start_instr(5'd9, 1'b0, 1'b0, n, term);
    repeat (2) step();
    check_val("ret1_rp_inc", int'(rp_inc), 2);
    step();
    check_val("ret2_pc_src", int'(pc_src), 2);
    step();

    start_instr(5'd8, 1'b0, 1'b0, n, term);
    repeat (2) step();
    apply_reset();

    run_instr(5'b01111, 1'b0, 1'b0, term);
    check_val("illegal_trap", int'(trap), 1);
    hold_term(term, 20);
    check_val("illegal_trap_held", int'(trap), 1);
    apply_reset();

    run_instr(5'd1, 1'b0, 1'b1, term);
    check_val("ovfl_trap", int'(trap), 1);
    hold_term(term, 5);
    apply_reset();

    run_instr(5'd31, 1'b0, 1'b0, term);
    check_val("halt_flag", int'(halted), 1);
    check_val("halt_b_write", int'(b_write), 0);
    hold_term(term, 20);
    apply_reset();

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 85)      op = 5'($urandom_range(0, 9));
      else if (r < 90) op = 5'd31;
      else             op = 5'($urandom_range(10, 30));
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), term);
      if (term != 0) begin
        hold_term(term, int'($urandom_range(1, 6)));
        apply_reset();
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
